dlfloat_mac_host: RTL and testbench

DLFLOAT_MAC_HOST -- requirements
Module: dlfloat_mac_host

---
 rtl/dlfloat_mac_host.sv | 153 +++++++++++++++
 tb/tb_dlfloat_mac_host.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dlfloat_mac_host.sv
// Host framer for a byte-serial DLFloat16 MAC device: issues operand pairs over a 16-bit link
// and reassembles byte-pair results. Define DLFLOAT_HOST_FIFO_EN for a 4-entry result FIFO.
module dlfloat_mac_host #(
    parameter int RES_LAT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic [15:0] link_data,
    input  logic [7:0]  link_byte,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        res_nan,
    output logic        res_zero
);

    function automatic logic [3:0] count_ones(input logic [RES_LAT-1:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < RES_LAT; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    logic               phase_r;
    logic               pend_r;
    logic [15:0]        opb_r;
    logic [15:0]        link_data_r;
    logic [RES_LAT-1:0] tag_r;
    logic [7:0]         low_r;

    logic               hs_s;
    logic               push_s;
    logic               pop_s;
    logic               full_s;
    logic [15:0]        push_data_s;
    logic [3:0]         stored_s;
    logic [3:0]         used_s;

    // A slot ends on a phase-1 edge; its result returns RES_LAT slots after the operand slot.
    assign hs_s        = op_valid & op_ready;
    assign push_s      = phase_r & tag_r[RES_LAT-1];
    assign push_data_s = {link_byte, low_r};
    assign pop_s       = res_valid & res_ready;
    assign used_s      = stored_s + count_ones(tag_r) + {3'b000, pend_r};

    // Phase, operand link, result tag pipeline and low-byte capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r     <= 1'b0;
            pend_r      <= 1'b0;
            opb_r       <= 16'h0000;
            link_data_r <= 16'h0000;
            tag_r       <= {RES_LAT{1'b0}};
            low_r       <= 8'h00;
        end else begin
            phase_r <= ~phase_r;
            if (phase_r) begin
                for (int i = RES_LAT - 1; i > 0; i--) begin
                    tag_r[i] <= tag_r[i-1];
                end
                tag_r[0]    <= pend_r;
                pend_r      <= hs_s;
                link_data_r <= hs_s ? op_a : 16'h0000;
                if (hs_s) begin
                    opb_r <= op_b;
                end
            end else begin
                low_r       <= link_byte;
                link_data_r <= pend_r ? opb_r : 16'h0000;
            end
        end
    end

`ifdef DLFLOAT_HOST_FIFO_EN
    localparam int RDEPTH = 4;

    logic [15:0] mem_r [0:3];
    logic [1:0]  wr_ptr_r;
    logic [1:0]  rd_ptr_r;
    logic [2:0]  cnt_r;

    // Circular result FIFO; pointers wrap naturally at 2 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                mem_r[i] <= 16'h0000;
            end
            wr_ptr_r <= 2'd0;
            rd_ptr_r <= 2'd0;
            cnt_r    <= 3'd0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_data_s;
                wr_ptr_r        <= wr_ptr_r + 2'd1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + 3'd1;
                2'b01:   cnt_r <= cnt_r - 3'd1;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign res_data = mem_r[rd_ptr_r];
    assign stored_s = {1'b0, cnt_r};
    assign full_s   = (cnt_r == 3'd4);
`else
    localparam int RDEPTH = 1;

    logic [15:0] hold_r;
    logic        full_r;

    // Single holding register for the one result allowed in the system.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_r <= 16'h0000;
            full_r <= 1'b0;
        end else begin
            if (push_s) begin
                hold_r <= push_data_s;
            end
            case ({push_s, pop_s})
                2'b10:   full_r <= 1'b1;
                2'b01:   full_r <= 1'b0;
                default: full_r <= full_r;
            endcase
        end
    end

    assign res_data = hold_r;
    assign stored_s = {3'b000, full_r};
    assign full_s   = full_r;
`endif

    assign op_ready  = phase_r & (used_s < 4'(RDEPTH));
    assign link_data = link_data_r;
    assign res_valid = (stored_s != 4'd0);
    assign res_nan   = (res_data == 16'hFFFF);
    assign res_zero  = (res_data == 16'h0000);

    // Credits must make a push into full storage impossible.
    assert property (@(posedge clk) disable iff (!rst_n) !(push_s && full_s));

endmodule

// File: tb/tb_dlfloat_mac_host.sv
// Directed bench for dlfloat_mac_host with a byte-serial MAC device model and result scoreboard.
module tb_dlfloat_mac_host;
    localparam int RES_LAT = 3;
`ifdef DLFLOAT_HOST_FIFO_EN
    localparam int RDEPTH = 4;
`else
    localparam int RDEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [15:0] op_a = 16'hDEAD;
    logic [15:0] op_b = 16'hBEEF;
    logic [15:0] link_data;
    logic [7:0]  link_byte = 8'hA5;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_data;
    logic        res_nan;
    logic        res_zero;

    int n_checks = 0;
    int n_errors = 0;
    int n_hs = 0;
    int n_res = 0;
    int cyc = 0;

    logic [15:0] cur_res = 16'h0000;
    logic [15:0] sa [0:15];
    logic [15:0] sb [0:15];
    logic [15:0] sr [0:15];

    int          pq_h [$];
    logic [15:0] pq_a [$];
    logic [15:0] pq_b [$];
    logic [15:0] pq_r [$];
    logic [15:0] exp_q [$];

    dlfloat_mac_host #(.RES_LAT(RES_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .link_data (link_data),
        .link_byte (link_byte),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_nan   (res_nan),
        .res_zero  (res_zero)
    );

    always #5 clk = ~clk;

    // Device model and scoreboard: checks the link word, returns result bytes, checks popped results.
    initial begin
        logic [15:0] exp_ld;
        logic [15:0] e;
        logic [15:0] r;
        logic [7:0]  nb;
        forever begin
            @(negedge clk);
            cyc++;
            exp_ld = 16'h0000;
            nb = 8'hA5;
            if (!rst_n) begin
                pq_h.delete(); pq_a.delete(); pq_b.delete(); pq_r.delete();
                exp_q.delete();
            end else begin
                while (pq_h.size() > 0 && cyc > pq_h[0] + 2 + 2 * RES_LAT) begin
                    void'(pq_h.pop_front()); void'(pq_a.pop_front());
                    void'(pq_b.pop_front()); void'(pq_r.pop_front());
                end
                foreach (pq_h[i]) begin
                    r = pq_r[i];
                    if (cyc == pq_h[i] + 1) exp_ld = pq_a[i];
                    if (cyc == pq_h[i] + 2) exp_ld = pq_b[i];
                    if (cyc == pq_h[i] + 1 + 2 * RES_LAT) nb = r[7:0];
                    if (cyc == pq_h[i] + 2 + 2 * RES_LAT) nb = r[15:8];
                end
            end
            n_checks++;
            if (link_data !== exp_ld) begin
                n_errors++;
                $display("FAIL link_data cycle %0d: got %h expected %h", cyc, link_data, exp_ld);
            end
            link_byte = nb;
            if (rst_n && res_valid && res_ready) begin
                n_res++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_result: got %h expected none", res_data);
                end else begin
                    e = exp_q.pop_front();
                    if (res_data !== e || res_nan !== (e == 16'hFFFF) || res_zero !== (e == 16'h0000)) begin
                        n_errors++;
                        $display("FAIL result: got %h nan %b zero %b expected %h nan %b zero %b",
                                 res_data, res_nan, res_zero, e, (e == 16'hFFFF), (e == 16'h0000));
                    end
                end
            end
            if (rst_n && op_valid && op_ready) begin
                n_hs++;
                pq_h.push_back(cyc); pq_a.push_back(op_a);
                pq_b.push_back(op_b); pq_r.push_back(cur_res);
                exp_q.push_back(cur_res);
            end
        end
    end

    task automatic send_pairs(input int n, input int budget, output int sent);
        sent = 0;
        for (int k = 0; k < budget && sent < n; k++) begin
            op_valid = 1'b1;
            op_a = sa[sent];
            op_b = sb[sent];
            cur_res = sr[sent];
            @(negedge clk);
            if (op_valid && op_ready) sent++;
            @(posedge clk); #1;
        end
        op_valid = 1'b0;
        op_a = 16'hDEAD;
        op_b = 16'hBEEF;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        @(negedge clk);
        n_checks++;
        if ({op_ready, res_valid, res_nan, res_zero} !== 4'b0001) begin
            n_errors++;
            $display("FAIL reset_flags: got rdy/val/nan/zero %b expected 0001",
                     {op_ready, res_valid, res_nan, res_zero});
        end
        n_checks++;
        if (res_data !== 16'h0000 || link_data !== 16'h0000) begin
            n_errors++;
            $display("FAIL reset_data: got res %h link %h expected 0000 0000", res_data, link_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (op_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL ready_cycle1: got %b expected 0", op_ready);
        end
        @(negedge clk);
        n_checks++;
        if (op_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL ready_cycle2: got %b expected 1", op_ready);
        end
        @(posedge clk); #1;
        idle(4);
    endtask

    task automatic test_single();
        int sent;
        int base;
        base = n_res;
        res_ready = 1'b1;
        sa[0] = 16'h3E00; sb[0] = 16'h3E00; sr[0] = 16'h3E00;
        send_pairs(1, 20, sent);
        idle(2 * RES_LAT + 8);
        n_checks++;
        if (sent !== 1 || n_res - base !== 1) begin
            n_errors++;
            $display("FAIL single_count: got sent %0d results %0d expected 1 1", sent, n_res - base);
        end
    endtask

    task automatic test_special();
        int sent;
        logic [15:0] vals [0:1];
        vals[0] = 16'hFFFF;
        vals[1] = 16'h0000;
        res_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sa[0] = 16'h7E00 + 16'(i); sb[0] = 16'h4000; sr[0] = vals[i];
            send_pairs(1, 20, sent);
            idle(2 * RES_LAT + 6);
            @(negedge clk);
            n_checks++;
            if (res_valid !== 1'b1 || res_data !== vals[i] || res_nan !== (i == 0) || res_zero !== (i == 1)) begin
                n_errors++;
                $display("FAIL special_%0d: got val %b data %h nan %b zero %b expected 1 %h %b %b",
                         i, res_valid, res_data, res_nan, res_zero, vals[i], (i == 0), (i == 1));
            end
            @(posedge clk); #1;
            res_ready = 1'b1;
            idle(1);
            res_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        int sent;
        int base;
        int rose;
        base = n_res;
        res_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            sa[i] = 16'h1000 + 16'(i); sb[i] = 16'h2000 + 16'(i); sr[i] = 16'h5000 + 16'(i * 3);
        end
        send_pairs(12, 80, sent);
        n_checks++;
        if (sent !== RDEPTH) begin
            n_errors++;
            $display("FAIL bp_accepted: got %0d expected %0d", sent, RDEPTH);
        end
        op_valid = 1'b1;
        op_a = sa[sent]; op_b = sb[sent]; cur_res = sr[sent];
        @(negedge clk);
        rose = op_ready;
        @(negedge clk);
        n_checks++;
        if ((rose | op_ready) !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_ready_low: got %b expected 0", rose | op_ready);
        end
        op_valid = 1'b0;
        @(posedge clk); #1;
        res_ready = 1'b1;
        idle(1);
        res_ready = 1'b0;
        rose = 0;
        for (int k = 0; k < 4 && rose == 0; k++) begin
            @(negedge clk);
            if (op_ready === 1'b1) rose = 1;
        end
        n_checks++;
        if (rose !== 1) begin
            n_errors++;
            $display("FAIL bp_ready_after_pop: got %0d expected 1", rose);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        idle(2 * RES_LAT + 10);
        n_checks++;
        if (n_res - base !== RDEPTH || exp_q.size() !== 0) begin
            n_errors++;
            $display("FAIL bp_drain: got %0d results %0d left expected %0d 0",
                     n_res - base, exp_q.size(), RDEPTH);
        end
    endtask

    task automatic test_back_to_back();
        int sent;
        int base;
        base = n_res;
        res_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sa[i] = 16'h3C00 + 16'(i * 17); sb[i] = 16'h4100 - 16'(i * 5);
            sr[i] = 16'hA000 ^ 16'(i * 257);
        end
        send_pairs(10, 400, sent);
        idle(2 * RES_LAT + 10);
        n_checks++;
        if (sent !== 10 || n_res - base !== 10 || exp_q.size() !== 0) begin
            n_errors++;
            $display("FAIL wrap: got sent %0d results %0d left %0d expected 10 10 0",
                     sent, n_res - base, exp_q.size());
        end
    endtask

    task automatic test_midflight_reset();
        int sent;
        int want;
        int base;
        int seen;
        want = (RDEPTH >= 2) ? 2 : 1;
        res_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sa[i] = 16'h3F00 + 16'(i); sb[i] = 16'h3D00; sr[i] = 16'h7777 + 16'(i);
        end
        send_pairs(want, 20, sent);
        n_checks++;
        if (sent !== want) begin
            n_errors++;
            $display("FAIL mid_sent: got %0d expected %0d", sent, want);
        end
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        res_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 4 * RES_LAT + 8; k++) begin
            @(negedge clk);
            if (res_valid !== 1'b0) seen++;
        end
        @(posedge clk); #1;
        n_checks++;
        if (seen !== 0) begin
            n_errors++;
            $display("FAIL mid_stale: got %0d valid cycles expected 0", seen);
        end
        base = n_res;
        sa[0] = 16'h3A00; sb[0] = 16'h3B00; sr[0] = 16'h3912;
        send_pairs(1, 20, sent);
        idle(2 * RES_LAT + 8);
        n_checks++;
        if (n_res - base !== 1) begin
            n_errors++;
            $display("FAIL mid_new_pair: got %0d results expected 1", n_res - base);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_special();
        test_backpressure();
        test_back_to_back();
        test_midflight_reset();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
